// File: rtl/program_sequencer.sv
// Next-PC sequencer: resolves predecoded control-flow flags against ALU status,
// keeps a register-based return-address stack, and halts on stack misuse.
module program_sequencer #(
   parameter int unsigned        ADDR_W    = 16,
   parameter int unsigned        STK_DEPTH = 8,
   parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          jmp,
   input  logic                          jze,
   input  logic                          jne,
   input  logic                          jov,
   input  logic                          jcy,
   input  logic                          ret,
   input  logic                          bsr,
   input  logic [ADDR_W-1:0]             target,
   input  logic                          flag_z,
   input  logic                          flag_ov,
   input  logic                          flag_cy,
   output logic [ADDR_W-1:0]             pc,
   output logic                          flush,
   output logic [$clog2(STK_DEPTH):0]    stk_cnt,
   output logic                          fault,
   output logic                          fault_ovf,
   output logic                          fault_unf
);

   localparam int unsigned PTR_W = $clog2(STK_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [0:0] StRun  = 1'b0;
   localparam logic [0:0] StHalt = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              flush_q, flush_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              push;

   logic [ADDR_W-1:0] stk_q [STK_DEPTH];
   logic [ADDR_W-1:0] pc_inc;
   logic [PTR_W-1:0]  push_idx;
   logic [PTR_W-1:0]  top_idx;
   logic              cond_taken;
   logic              stk_full;
   logic              stk_empty;

   assign pc_inc    = pc_q + ADDR_W'(1);
   assign push_idx  = cnt_q[PTR_W-1:0];
   assign top_idx   = cnt_q[PTR_W-1:0] - PTR_W'(1);
   assign stk_full  = (cnt_q == CNT_W'(STK_DEPTH));
   assign stk_empty = (cnt_q == '0);

   assign cond_taken = jmp | (jze & flag_z) | (jne & ~flag_z) |
                       (jov & flag_ov) | (jcy & flag_cy);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      flush_d = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      if (state_q == StRun && en) begin
         if (ret) begin
            if (stk_empty) begin
               unf_d   = 1'b1;
               state_d = StHalt;
            end else begin
               pc_d    = stk_q[top_idx];
               cnt_d   = cnt_q - CNT_W'(1);
               flush_d = 1'b1;
            end
         end else if (bsr) begin
            if (stk_full) begin
               ovf_d   = 1'b1;
               state_d = StHalt;
            end else begin
               push    = 1'b1;
               pc_d    = target;
               cnt_d   = cnt_q + CNT_W'(1);
               flush_d = 1'b1;
            end
         end else if (cond_taken) begin
            pc_d    = target;
            flush_d = 1'b1;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         pc_q    <= RESET_VEC;
         cnt_q   <= '0;
         flush_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage needs no reset: cnt_q alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         stk_q[push_idx] <= pc_inc;
      end
   end

   assign pc        = pc_q;
   assign flush     = flush_q;
   assign stk_cnt   = cnt_q;
   assign fault_ovf = ovf_q;
   assign fault_unf = unf_q;
   assign fault     = ovf_q | unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with hand-computed expectations.
module tb_program_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, jmp, jze, jne, jov, jcy, ret, bsr;
   logic [15:0] target;
   logic        flag_z, flag_ov, flag_cy;
   logic [15:0] pc;
   logic        flush;
   logic [3:0]  stk_cnt;
   logic        fault, fault_ovf, fault_unf;

   int tests = 0;
   int fails = 0;

   program_sequencer #(
      .ADDR_W   (16),
      .STK_DEPTH(8),
      .RESET_VEC(16'h0000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .jmp      (jmp),
      .jze      (jze),
      .jne      (jne),
      .jov      (jov),
      .jcy      (jcy),
      .ret      (ret),
      .bsr      (bsr),
      .target   (target),
      .flag_z   (flag_z),
      .flag_ov  (flag_ov),
      .flag_cy  (flag_cy),
      .pc       (pc),
      .flush    (flush),
      .stk_cnt  (stk_cnt),
      .fault    (fault),
      .fault_ovf(fault_ovf),
      .fault_unf(fault_unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_flags();
      jmp = 0; jze = 0; jne = 0; jov = 0; jcy = 0; ret = 0; bsr = 0;
   endtask

   task automatic check_state(input string tag, input logic [15:0] epc, input logic efl,
                              input logic [3:0] ecnt);
      check({tag, ".pc"}, 32'(pc), 32'(epc));
      check({tag, ".flush"}, 32'(flush), 32'(efl));
      check({tag, ".cnt"}, 32'(stk_cnt), 32'(ecnt));
   endtask

   initial begin
      rst_n = 0; en = 0; target = 16'h0;
      flag_z = 0; flag_ov = 0; flag_cy = 0;
      clear_flags();
      #12;
      check_state("reset", 16'h0000, 0, 0);
      check("reset.fault", 32'({fault, fault_ovf, fault_unf}), 32'h0);
      rst_n = 1;
      tick();

      // 1: sequential advance
      en = 1;
      tick(); check_state("seq1", 16'h0001, 0, 0);
      tick(); check_state("seq2", 16'h0002, 0, 0);
      tick(); check_state("seq3", 16'h0003, 0, 0);

      // en=0 ignores flags
      en = 0; jmp = 1; target = 16'h0777;
      tick(); check_state("hold", 16'h0003, 0, 0);

      // 2: jmp, then untaken jze
      en = 1; target = 16'h0040;
      tick(); check_state("jmp", 16'h0040, 1, 0);
      clear_flags(); jze = 1; flag_z = 0;
      tick(); check_state("jze_nt", 16'h0041, 0, 0);

      // other conditionals
      clear_flags(); jne = 1; flag_z = 0; target = 16'h0080;
      tick(); check_state("jne_t", 16'h0080, 1, 0);
      clear_flags(); jov = 1; flag_ov = 1; target = 16'h0090;
      tick(); check_state("jov_t", 16'h0090, 1, 0);
      clear_flags(); jcy = 1; flag_cy = 0; target = 16'h0500;
      tick(); check_state("jcy_nt", 16'h0091, 0, 0);
      clear_flags(); jze = 1; flag_z = 1; target = 16'h0010;
      tick(); check_state("jze_t", 16'h0010, 1, 0);
      flag_z = 0; flag_ov = 0;

      // 3: bsr/ret from 0x0010
      clear_flags(); bsr = 1; target = 16'h0100;
      tick(); check_state("bsr", 16'h0100, 1, 1);
      clear_flags(); ret = 1;
      tick(); check_state("ret", 16'h0011, 1, 0);
      // nested LIFO order
      clear_flags(); bsr = 1; target = 16'h0100;
      tick(); check_state("nest_b1", 16'h0100, 1, 1);
      target = 16'h0200;
      tick(); check_state("nest_b2", 16'h0200, 1, 2);
      clear_flags(); ret = 1;
      tick(); check_state("nest_r1", 16'h0101, 1, 1);
      tick(); check_state("nest_r2", 16'h0012, 1, 0);
      clear_flags();
      tick(); check_state("after_ret", 16'h0013, 0, 0);

      // 4: fill stack to depth, then overflow
      bsr = 1;
      for (int i = 0; i < 8; i++) begin
         target = 16'h0200 + 16'(i);
         tick();
      end
      check_state("full", 16'h0207, 1, 8);
      check("full.fault", 32'({fault, fault_ovf, fault_unf}), 32'h0);
      target = 16'h0300;
      tick();
      check_state("ovf", 16'h0207, 0, 8);
      check("ovf.fault", 32'({fault, fault_ovf, fault_unf}), 32'b110);
      clear_flags(); jmp = 1; target = 16'h0400;
      tick(); tick();
      check_state("halt", 16'h0207, 0, 8);
      check("halt.fault", 32'({fault, fault_ovf, fault_unf}), 32'b110);

      // reset mid-HALT discards stack and faults
      #2; rst_n = 0; #1;
      check_state("rst_halt", 16'h0000, 0, 0);
      check("rst_halt.fault", 32'({fault, fault_ovf, fault_unf}), 32'h0);
      clear_flags();
      #3; rst_n = 1;

      // 5: ret on empty stack
      ret = 1;
      tick();
      check_state("unf", 16'h0000, 0, 0);
      check("unf.fault", 32'({fault, fault_ovf, fault_unf}), 32'b101);
      clear_flags();
      tick();
      check("unf.frozen", 32'(pc), 32'h0);
      #2; rst_n = 0; #1;
      check("rst_unf.fault", 32'({fault, fault_ovf, fault_unf}), 32'h0);
      #3; rst_n = 1;

      // 6: wrap and priority
      jmp = 1; target = 16'hFFFF;
      tick(); check_state("to_ffff", 16'hFFFF, 1, 0);
      clear_flags();
      tick(); check_state("wrap", 16'h0000, 0, 0);
      jmp = 1; target = 16'hFFFF;
      tick();
      clear_flags(); bsr = 1; target = 16'h0050;
      tick(); check_state("bsr_wrap", 16'h0050, 1, 1);
      clear_flags(); jmp = 1; ret = 1; target = 16'h0090;
      tick(); check_state("ret_wins", 16'h0000, 1, 0);
      clear_flags();
      tick(); check_state("final", 16'h0001, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
